// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, stop bit.
// Transmit is a level request; holding it high yields back-to-back frames.
module uart_transmitter #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int BAUD_DIV  = CLK_FREQ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       Transmit,
    input  logic [7:0] data,
    output logic       TxD
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    logic [1:0]       rst_pipe;
    logic             rst_sync_n;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       idx;
    logic [2:0]       idx_nxt;
    logic [7:0]       shreg;
    logic [7:0]       shreg_nxt;
    logic             txd_q;
    logic             txd_nxt;
    logic             bit_end;

    // Assert asynchronously, release only after two clean clock edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_pipe[1];

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            txd_q <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            shreg <= shreg_nxt;
            txd_q <= txd_nxt;
        end
    end

    assign bit_end = (cnt == CNT_MAX);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        txd_nxt   = txd_q;
        unique case (state)
            IDLE: begin
                txd_nxt = 1'b1;
                if (Transmit) begin
                    shreg_nxt = data;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    txd_nxt   = 1'b0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_nxt   = '0;
                    txd_nxt   = shreg[0];
                    shreg_nxt = {1'b0, shreg[7:1]};
                    state_nxt = DATA;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nxt = '0;
                    // The last data bit hands over to the stop bit
                    if (idx == 3'd7) begin
                        txd_nxt   = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        idx_nxt   = idx + 3'd1;
                        txd_nxt   = shreg[0];
                        shreg_nxt = {1'b0, shreg[7:1]};
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                txd_nxt = 1'b1;
                if (bit_end) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                txd_nxt   = 1'b1;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    assign TxD = txd_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: cycle-accurate line model built from the
// frame layout, directed scenarios plus randomized request/data traffic.
module tb_uart_transmitter;

    localparam int BD     = 16;
    localparam int DEF_BD = 100_000_000 / 9600;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       transmit = 1'b0;
    logic [7:0] data = 8'h00;
    logic       txd;
    logic       transmit_def = 1'b0;
    logic [7:0] data_def = 8'hFF;
    logic       txd_def;

    always #5 clk = ~clk;

    uart_transmitter #(
        .CLK_FREQ (BD * 9600),
        .BAUD_RATE(9600),
        .BAUD_DIV (BD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Transmit(transmit),
        .data    (data),
        .TxD     (txd)
    );

    uart_transmitter dut_def (
        .clk     (clk),
        .rst_n   (rst_n),
        .Transmit(transmit_def),
        .data    (data_def),
        .TxD     (txd_def)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line model: a launched frame is the 10-bit word {1, data, 0}
    // sent LSB first, each bit BD cycles long.
    bit         active = 1'b0;
    bit         in_reset = 1'b1;
    int         pos = 0;
    logic [9:0] frame = '1;
    int         cyc = 0;
    logic       prev_txd = 1'b1;
    int         high_run = 1000;
    int         starts[$];

    task automatic tick();
        logic exp;
        @(negedge clk);
        cyc++;
        if (in_reset) begin
            active = 1'b0;
        end else if (active) begin
            pos++;
            if (pos == 10 * BD) active = 1'b0;
        end else if (transmit) begin
            active = 1'b1;
            pos    = 0;
            frame  = {1'b1, data, 1'b0};
        end
        exp = active ? frame[pos / BD] : 1'b1;
        check("txd", {31'd0, txd}, {31'd0, exp});
        if (txd === 1'b1) begin
            high_run++;
        end else begin
            if (prev_txd === 1'b1 && high_run > BD) starts.push_back(cyc);
            high_run = 0;
        end
        prev_txd = txd;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_reset = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        in_reset = 1'b0;
    endtask

    task automatic reset_mid(input logic [7:0] d, input int offset);
        data     = d;
        transmit = 1'b1;
        tick();
        transmit = 1'b0;
        repeat (offset) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_txd", {31'd0, txd}, 32'd1);
        in_reset = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        in_reset = 1'b0;
        data     = d;
        transmit = 1'b1;
        tick();
        transmit = 1'b0;
        repeat (10 * BD + 20) tick();
    endtask

    initial begin
        int n;
        int width;
        int len;

        do_reset();
        repeat (100) tick();

        // Single pulse with 0xAB
        data     = 8'hAB;
        transmit = 1'b1;
        tick();
        transmit = 1'b0;
        data     = 8'h00;
        repeat (10 * BD + 30) tick();

        // Back-to-back, data changed while the first frame is in flight
        starts.delete();
        data     = 8'hAA;
        transmit = 1'b1;
        repeat (60) tick();
        data = 8'hBB;
        repeat (10 * BD + 21) tick();
        transmit = 1'b0;
        repeat (10 * BD + 40) tick();
        check("b2b_starts", (starts.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
        if (starts.size() >= 2) begin
            check("b2b_period", starts[1] - starts[0], 10 * BD + 1);
        end

        // Reset during data bit 3 of 0xCC, then during a zero bit of 0x00
        reset_mid(8'hCC, 4 * BD + 5);
        reset_mid(8'h00, 3 * BD + 7);

        // Transmit dropped during the stop bit: no further start bit
        data     = 8'h5A;
        transmit = 1'b1;
        repeat (9 * BD + 3) tick();
        transmit = 1'b0;
        repeat (3 * BD) tick();

        // Randomized request levels with data churning every cycle
        for (int s = 0; s < 40; s++) begin
            transmit = 1'($urandom_range(0, 1));
            len      = $urandom_range(1, 250);
            for (int c = 0; c < len; c++) begin
                data = 8'($urandom);
                tick();
            end
        end
        transmit = 1'b0;
        repeat (10 * BD + 5) tick();

        // Default parameters: start bit width
        transmit_def = 1'b1;
        tick();
        transmit_def = 1'b0;
        n = 0;
        while (txd_def !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        check("def_start_seen", {31'd0, txd_def}, 32'd0);
        width = 0;
        while (txd_def === 1'b0 && width < 20000) begin
            tick();
            width++;
        end
        check("def_start_width", width, DEF_BD);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
